soc_event_timestamper: RTL

- Downstream AXI-Stream consumer of the timer block's event stream.
- Timestamps each incoming event beat with a free-running cycle counter and buffers {timestamp, event_count} pairs in a FIFO.
- Emits each pair as a 2-beat AXIS packet toward the SoC DMA/trace path.
- Never back-pressures the timer. Events arriving on a full FIFO are dropped and counted.

---
 rtl/soc_event_timestamper_if.sv | 12 +
 rtl/soc_event_timestamper.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/soc_event_timestamper_if.sv
// AXI-Stream beat bundle; one instance per direction of the event timestamper.
interface soc_event_timestamper_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] TDATA;
    logic                  TVALID;
    logic                  TREADY;
    logic                  TLAST;

    modport master (output TDATA, output TVALID, output TLAST, input TREADY);
    modport slave  (input TDATA, input TVALID, input TLAST, output TREADY);
endinterface

// File: rtl/soc_event_timestamper.sv
// Timestamps timer events, buffers {ts, count} and emits 2-beat AXIS packets (2 cycles in to M_TVALID).
// Never stalls the timer: events hitting a full FIFO are dropped and counted; output obeys M_TREADY.
module soc_event_timestamper #(
    parameter int DATA_WIDTH = 32,
    parameter int TS_WIDTH   = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                         ACLK,
    input  logic                         ARESETN,
    soc_event_timestamper_if.slave       s_axis,
    soc_event_timestamper_if.master      m_axis,
    input  logic                         ts_clear,
    input  logic                         overflow_clr,
    output logic                         overflow,
    output logic [15:0]                  drop_count,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = TS_WIDTH + DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        TS_BEAT,
        DATA_BEAT
    } state_e;

    logic [TS_WIDTH-1:0]   ts_q, ts_d;
    logic                  s_tready_q;
    logic [EW-1:0]         mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]         level_q, level_d;
    logic [15:0]           drop_q, drop_d;
    logic                  ovf_q, ovf_d;
    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] m_tdata_q, m_tdata_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic                  m_tvalid_q, m_tvalid_d;
    logic                  m_tlast_q, m_tlast_d;

    logic                  accept, fifo_full, fifo_empty;
    logic                  push, pop, drop;
    logic [EW-1:0]         head;
    logic [TS_WIDTH-1:0]   head_ts;
    logic [DATA_WIDTH-1:0] head_data;
    logic                  unused_tlast;

    // Every timer beat is a standalone event, so TLAST carries nothing.
    assign unused_tlast = s_axis.TLAST;

    assign ts_d = ts_clear ? '0 : ts_q + TS_WIDTH'(1);

    assign fifo_full  = (level_q == LW'(FIFO_DEPTH));
    assign fifo_empty = (level_q == '0);
    assign accept     = s_axis.TVALID && s_tready_q;
    // A pop in the same cycle frees the slot the new event lands in.
    assign push       = accept && (!fifo_full || pop);
    assign drop       = accept && fifo_full && !pop;

    assign head      = mem_q[rd_ptr_q];
    assign head_ts   = head[EW-1:DATA_WIDTH];
    assign head_data = head[DATA_WIDTH-1:0];

    always_comb begin
        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (pop && !push) begin
            level_d = level_q - LW'(1);
        end
    end

    assign drop_d = (drop && (drop_q != 16'hFFFF)) ? drop_q + 16'd1 : drop_q;
    assign ovf_d  = drop ? 1'b1 : (overflow_clr ? 1'b0 : ovf_q);

    always_comb begin
        state_d    = state_q;
        m_tdata_d  = m_tdata_q;
        m_tvalid_d = m_tvalid_q;
        m_tlast_d  = m_tlast_q;
        hold_d     = hold_q;
        pop        = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_d    = TS_BEAT;
                    m_tvalid_d = 1'b1;
                    m_tdata_d  = DATA_WIDTH'(head_ts);
                    m_tlast_d  = 1'b0;
                    hold_d     = head_data;
                end
            end
            TS_BEAT: begin
                if (m_axis.TREADY) begin
                    state_d   = DATA_BEAT;
                    m_tdata_d = hold_q;
                    m_tlast_d = 1'b1;
                end
            end
            DATA_BEAT: begin
                if (m_axis.TREADY) begin
                    if (!fifo_empty) begin
                        // Chain straight into the next packet without an idle bubble.
                        pop       = 1'b1;
                        state_d   = TS_BEAT;
                        m_tdata_d = DATA_WIDTH'(head_ts);
                        m_tlast_d = 1'b0;
                        hold_d    = head_data;
                    end else begin
                        state_d    = IDLE;
                        m_tvalid_d = 1'b0;
                        m_tlast_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                m_tvalid_d = 1'b0;
                m_tlast_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            ts_q       <= '0;
            s_tready_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            drop_q     <= '0;
            ovf_q      <= 1'b0;
            state_q    <= IDLE;
            m_tdata_q  <= '0;
            m_tvalid_q <= 1'b0;
            m_tlast_q  <= 1'b0;
            hold_q     <= '0;
        end else begin
            ts_q       <= ts_d;
            s_tready_q <= 1'b1;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            level_q    <= level_d;
            drop_q     <= drop_d;
            ovf_q      <= ovf_d;
            state_q    <= state_d;
            m_tdata_q  <= m_tdata_d;
            m_tvalid_q <= m_tvalid_d;
            m_tlast_q  <= m_tlast_d;
            hold_q     <= hold_d;
        end
    end

    // Storage needs no reset: the pointers and level define what is valid.
    always_ff @(posedge ACLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {ts_q, s_axis.TDATA};
        end
    end

    assign s_axis.TREADY = s_tready_q;
    assign m_axis.TDATA  = m_tdata_q;
    assign m_axis.TVALID = m_tvalid_q;
    assign m_axis.TLAST  = m_tlast_q;
    assign overflow      = ovf_q;
    assign drop_count    = drop_q;
    assign fifo_level    = level_q;

endmodule
